// File: rtl/seq_bin2bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Latency: done pulses in the cycle after the N-th iteration edge (N+1 edges after start is sampled).
// Backpressure: start is only accepted in IDLE; starts while busy are dropped, nothing is queued.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset, dominates all other inputs
//   start - launch a conversion of bin (sampled only while idle)
//   bin   - N-bit unsigned binary input
//   busy  - high while a conversion is running
//   done  - one-cycle pulse when bcd has been updated
//   bcd   - D packed BCD digits, digit 0 (units) in bits [3:0]
module seq_bin2bcd #(
  parameter int N = 12,
  parameter int D = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   bin,
  output logic           busy,
  output logic           done,
  output logic [4*D-1:0] bcd
);

  localparam int CW = $clog2(N + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  // D digits must be able to hold the largest N-bit value, otherwise a
  // digit could overflow and the result would silently be wrong.
  generate
    if (10 ** D <= (2 ** N) - 1) begin : g_illegal_width
      $error("seq_bin2bcd: D BCD digits cannot represent every N-bit value");
    end
  endgenerate

  logic [0:0]     state;
  logic [N-1:0]   binreg;
  logic [4*D-1:0] scratch;
  logic [CW-1:0]  count;

  logic [4*D-1:0] adj;
  logic [4*D-1:0] next_scratch;
  logic [N-1:0]   next_bin;

  // All digits are corrected from their pre-adjust values in parallel, then
  // the {scratch, binreg} pair is shifted left by one bit.
  always_comb begin
    adj = '0;
    for (int i = 0; i < D; i++) begin
      adj[4*i +: 4] = (scratch[4*i +: 4] >= 4'd5) ? (scratch[4*i +: 4] + 4'd3)
                                                   : scratch[4*i +: 4];
    end
    next_scratch = {adj[4*D-2:0], binreg[N-1]};
    next_bin     = {binreg[N-2:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      binreg  <= '0;
      scratch <= '0;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= SHIFT;
            binreg  <= bin;
            scratch <= '0;
            count   <= CW'(N);
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          scratch <= next_scratch;
          binreg  <= next_bin;
          count   <= count - CW'(1);
          // Last iteration: publish the fully shifted scratch directly.
          if (count == CW'(1)) begin
            state <= IDLE;
            bcd   <= next_scratch;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_bin2bcd.sv
module tb_seq_bin2bcd;

  localparam int N = 12;
  localparam int D = 4;

  logic           clk;
  logic           rst;
  logic           start;
  logic [N-1:0]   bin;
  logic           busy;
  logic           done;
  logic [4*D-1:0] bcd;

  int errors;
  int checks;

  seq_bin2bcd #(.N(N), .D(D)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal digits by plain division.
  function automatic logic [4*D-1:0] ref_bcd(input int v);
    logic [4*D-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Drive start for one cycle; returns at the first sample point after the start edge.
  task automatic launch(input int v);
    bin   = N'(v);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for done. k = sample index (1 = first sample after start edge), 0 on timeout.
  // Also reports how many samples had busy=1, whether busy and done overlapped,
  // and whether bcd moved away from 'hold' before done.
  task automatic wait_done(input logic [4*D-1:0] hold, output int k, output int nbusy,
                           output bit overlap, output bit moved);
    k = 0; nbusy = 0; overlap = 0; moved = 0;
    for (int i = 1; i <= 40; i++) begin
      if (busy && done) overlap = 1;
      if (done) begin
        k = i;
        return;
      end
      if (busy) nbusy++;
      if (bcd !== hold) moved = 1;
      @(negedge clk);
    end
  endtask

  task automatic convert_and_check(input int v, input string name);
    int k, nb;
    bit ov, mv;
    logic [4*D-1:0] hold;
    hold = bcd;
    launch(v);
    wait_done(hold, k, nb, ov, mv);
    checks++;
    if (k != N + 1) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d (bin=%0d)", name, k, N + 1, v);
    end
    checks++;
    if (bcd !== ref_bcd(v)) begin
      errors++;
      $display("FAIL %s bcd: got %h want %h (bin=%0d)", name, bcd, ref_bcd(v), v);
    end
    checks++;
    if (nb != N || ov || mv) begin
      errors++;
      $display("FAIL %s busy/hold: busy_cycles=%0d want %0d overlap=%0d bcd_moved=%0d",
               name, nb, N, ov, mv);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s pulse: done=%b busy=%b want 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bin = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd !== '0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b bcd=%h want 0 0 0000", busy, done, bcd);
    end
  endtask

  task automatic test_zero();
    convert_and_check(0, "zero");
  endtask

  task automatic test_corners();
    convert_and_check(4095, "max4095");
    convert_and_check(3969, "mul63x63");
    convert_and_check(36, "mul6x6");
    convert_and_check(9, "nine");
    convert_and_check(10, "ten");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      convert_and_check(int'($urandom_range(0, 4095)), "random");
  endtask

  task automatic test_ignored_start();
    int v, k, nb;
    bit ov, mv;
    logic [4*D-1:0] hold;
    v = int'($urandom_range(1000, 4095));
    hold = bcd;
    launch(v);
    @(negedge clk);
    bin = 12'd999;
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_done(hold, k, nb, ov, mv);
    checks++;
    if (k != N + 1 - 4) begin
      errors++;
      $display("FAIL ignored_start latency: got %0d want %0d", k, N + 1 - 4);
    end
    checks++;
    if (bcd !== ref_bcd(v) || mv) begin
      errors++;
      $display("FAIL ignored_start bcd: got %h want %h moved=%0d", bcd, ref_bcd(v), mv);
    end
    @(negedge clk);
    // A dropped start must not have started a second conversion.
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ignored_start requeue: busy=%b want 0", busy);
    end
  endtask

  task automatic test_abort();
    bit saw_done;
    launch(1234);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd !== '0) begin
      errors++;
      $display("FAIL abort: busy=%b done=%b bcd=%h want 0 0 0000", busy, done, bcd);
    end
    saw_done = 0;
    for (int i = 0; i < 20; i++) begin
      if (done || busy) saw_done = 1;
      @(negedge clk);
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL abort_no_done: activity seen after abort, want none");
    end
  endtask

  task automatic test_back_to_back();
    int a, k, nb;
    bit ov, mv;
    logic [4*D-1:0] hold;
    a = int'($urandom_range(101, 4095));
    hold = bcd;
    launch(a);
    wait_done(hold, k, nb, ov, mv);
    checks++;
    if (k != N + 1 || bcd !== ref_bcd(a)) begin
      errors++;
      $display("FAIL b2b first: latency=%0d bcd=%h want %0d %h", k, bcd, N + 1, ref_bcd(a));
    end
    // Start issued in the done cycle.
    launch(100);
    wait_done(ref_bcd(a), k, nb, ov, mv);
    checks++;
    if (k != N + 1) begin
      errors++;
      $display("FAIL b2b second latency: got %0d want %0d", k, N + 1);
    end
    checks++;
    if (mv) begin
      errors++;
      $display("FAIL b2b hold: bcd changed before second done, want %h held", ref_bcd(a));
    end
    checks++;
    if (bcd !== 16'h0100) begin
      errors++;
      $display("FAIL b2b second bcd: got %h want 0100", bcd);
    end
    @(negedge clk);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    start = 1'b0;
    bin = '0;
    @(negedge clk);
    test_reset();
    test_zero();
    test_corners();
    test_random();
    test_ignored_start();
    test_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_bin2bcd.md
Name: seq_bin2bcd

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Sits directly downstream of the 6-bit sequential shift-add multiplier and consumes its 12-bit unsigned product.
- Output feeds the board's 4-digit seven-segment display path.
- Start/busy/done handshake, so the multiplier control can launch a conversion once its product is final.

Parameters:
- N, 12, binary input width in bits.
- D, 4, number of BCD output digits. Legal only if 10^D > 2^N - 1; otherwise elaboration is an error.

Ports:
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  synchronous, active-high reset
- start  input  1  request conversion of bin; sampled only in IDLE
- bin  input  N  unsigned binary value (multiplier product)
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when bcd is updated
- bcd  output  4*D  packed BCD result; digit i occupies bits [4i+3:4i], digit 0 = units

Behaviour:
- Reset and clock: one clock, clk. Reset is rst, synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, bcd=0, internal shift register and counter = 0.
- rst dominates all other inputs. Asserting rst mid-conversion aborts it at the next edge; bcd returns to 0 and no done is produced.
- States:
  - IDLE: waiting for start.
  - SHIFT: performs N iterations.
- IDLE -> SHIFT: on an edge with start=1.
  - Latch bin into the internal binary shift register.
  - Clear the BCD scratch register.
  - Set count=N; set busy=1.
- SHIFT, each edge:
  - For every scratch digit >= 5, add 3 to that digit. All digits are adjusted in parallel from the pre-adjust value.
  - Then shift {scratch, binreg} left by 1.
  - Decrement count.
- SHIFT -> IDLE: on the edge where count goes 1 -> 0.
  - Copy the final shifted scratch to bcd.
  - done=1 for the following cycle only; busy=0.
- Latency: start sampled at edge E0. Iterations occur at edges E1..EN. bcd is valid and done=1 in the cycle after EN. busy=1 in the cycles after E0..E(N-1).
- bcd holds its last result until the next completion or reset; it does not change during SHIFT.
- Ignored starts:
  - start while busy=1 is ignored; no queuing.
  - bin changes during SHIFT have no effect.
- Back-to-back: start=1 in the done cycle is accepted (state is IDLE). The new conversion begins and bcd keeps the old value until its own done.
- Arithmetic:
  - Scratch is 4*D bits; the digit adjust is 4-bit modulo.
  - With the legality rule enforced, no digit ever exceeds 9 after a shift, and no overflow output is needed.
- done and busy are never high in the same cycle.

Test Plan:
- Reset, then start with bin=0 -> done pulse exactly N+1 cycles after the start edge; bcd=16'h0000; busy high for exactly N cycles.
- bin=12'd4095 -> bcd=16'h4095.
- bin=12'd3969 (63x63, multiplier maximum) -> bcd=16'h3969.
- bin=12'd36 (6x6) -> bcd=16'h0036.
- start=1 for 3 cycles mid-conversion with bin changed to 12'd999 -> ignored; completed result is the original value.
- rst asserted 5 cycles into a conversion of 12'd1234 -> next cycle busy=0, bcd=0, no done pulse.
- Back-to-back: start asserted in the done cycle with bin=12'd100 -> second done N+1 cycles later with bcd=16'h0100; the earlier result is held until then.
